// File: rtl/vend_pkg.sv
// Purpose: shared types and constants for the vending sequencer (state enum, coin codes, credit width, default prices).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    localparam int CREDIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Default price table, product 0..3, in credit units.
    localparam int DEF_PRICE0 = 3;
    localparam int DEF_PRICE1 = 4;
    localparam int DEF_PRICE2 = 5;
    localparam int DEF_PRICE3 = 6;

    // Credit value of a coin code; the invalid code is worth nothing.
    function automatic logic [1:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_ONE: return 2'd1;
            COIN_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Purpose: bundle of customer/motor/change-unit signals around the vending sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = environment side, slave = sequencer side.
interface vend_if;
    logic [1:0]                    coin;
    logic                          sel_valid;
    logic [1:0]                    sel_id;
    logic                          cancel;
    logic                          disp_req;
    logic [1:0]                    disp_id;
    logic                          disp_done;
    logic                          chg_req;
    logic                          chg_ack;
    logic [vend_pkg::CREDIT_W-1:0] credit;
    logic                          busy;
    logic                          coin_rej;
    logic                          sel_nack;
    logic                          fault;

    modport master (
        output coin, sel_valid, sel_id, cancel, disp_done, chg_ack,
        input  disp_req, disp_id, chg_req, credit, busy, coin_rej, sel_nack, fault
    );

    modport slave (
        input  coin, sel_valid, sel_id, cancel, disp_done, chg_ack,
        output disp_req, disp_id, chg_req, credit, busy, coin_rej, sel_nack, fault
    );
endinterface

// File: rtl/vend_timer.sv
// Purpose: dispense watchdog; counts enabled cycles since clear, flags the last allowed cycle.
// Latency: expired flag is combinational from the count, count updates one cycle after i_en.
// Backpressure: none.
// Ports: clk, rst_n; i_clear restarts the count, i_en advances it; o_expired high on the
//        DISP_TIMEOUT-th cycle since clear.
module vend_timer #(
    parameter int DISP_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int TW = $clog2(DISP_TIMEOUT + 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    // Count is 0 on the first waiting cycle, so cycle N of waiting sees N-1.
    assign o_expired = (r_cnt == TW'(DISP_TIMEOUT - 1));
endmodule

// File: rtl/vend_sequencer.sv
// Purpose: vending sequencer; accepts coins, sells products, dispenses and pays change.
// Latency: every output is registered, reacting one cycle after the sampled inputs.
// Backpressure: disp_req held until disp_done (or watchdog), chg_req held until credit drained by chg_ack.
// Ports: clk, rst_n; bus (vend_if.slave) carries coin/sel/cancel/done/ack in and
//        disp_req/disp_id/chg_req/credit/busy/coin_rej/sel_nack/fault out.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0       = DEF_PRICE0,
    parameter int PRICE1       = DEF_PRICE1,
    parameter int PRICE2       = DEF_PRICE2,
    parameter int PRICE3       = DEF_PRICE3,
    parameter int CREDIT_MAX   = 12,
    parameter int DISP_TIMEOUT = 64
) (
    input logic   clk,
    input logic   rst_n,
    vend_if.slave bus
);
    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    return CREDIT_W'(PRICE0);
            2'd1:    return CREDIT_W'(PRICE1);
            2'd2:    return CREDIT_W'(PRICE2);
            default: return CREDIT_W'(PRICE3);
        endcase
    endfunction

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_price, w_price_nxt;
    logic [1:0]          r_disp_id, w_disp_id_nxt;
    logic                r_coin_rej, w_coin_rej_nxt;
    logic                r_sel_nack, w_sel_nack_nxt;
    logic                r_fault, w_fault_nxt;
    logic                r_disp_req, r_chg_req, r_busy;
    logic                r_live;
    logic                w_tmr_clear, w_tmr_en, w_tmr_expired;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [1:0]          w_coin_val;
    logic [CREDIT_W:0]   w_avail, w_sum;

    assign w_sel_price = price_of(bus.sel_id);
    assign w_coin_val  = coin_value(bus.coin);

    vend_timer #(.DISP_TIMEOUT(DISP_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_price_nxt    = r_price;
        w_disp_id_nxt  = r_disp_id;
        w_coin_rej_nxt = 1'b0;
        w_sel_nack_nxt = 1'b0;
        w_fault_nxt    = 1'b0;
        w_tmr_clear    = 1'b0;
        w_tmr_en       = 1'b0;
        w_avail        = {1'b0, r_credit};
        w_sum          = '0;

        // r_live is low only on the first edge after reset release: inputs are ignored there.
        if (r_live) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cancel) begin
                        if (r_credit != '0) w_state_nxt = ST_CHANGE;
                    end else if (bus.sel_valid) begin
                        // Price is checked against the credit held before this cycle's coin.
                        if (r_credit >= w_sel_price) begin
                            w_avail       = {1'b0, r_credit} - {1'b0, w_sel_price};
                            w_price_nxt   = w_sel_price;
                            w_disp_id_nxt = bus.sel_id;
                            w_state_nxt   = ST_DISPENSE;
                            w_tmr_clear   = 1'b1;
                        end else begin
                            w_sel_nack_nxt = 1'b1;
                        end
                    end
                    // A same-cycle coin lands on top of the post-purchase credit.
                    w_sum = w_avail + {{(CREDIT_W-1){1'b0}}, w_coin_val};
                    if (bus.coin == COIN_BAD) begin
                        w_coin_rej_nxt = 1'b1;
                    end else if (bus.coin != COIN_NONE) begin
                        if (w_sum <= (CREDIT_W+1)'(CREDIT_MAX)) w_avail = w_sum;
                        else                                    w_coin_rej_nxt = 1'b1;
                    end
                    w_credit_nxt = w_avail[CREDIT_W-1:0];
                end
                ST_DISPENSE: begin
                    w_coin_rej_nxt = (bus.coin != COIN_NONE);
                    if (bus.disp_done) begin
                        w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
                    end else if (w_tmr_expired) begin
                        // Motor never finished: refund the sale and report it.
                        w_credit_nxt = r_credit + r_price;
                        w_fault_nxt  = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
                ST_CHANGE: begin
                    w_coin_rej_nxt = (bus.coin != COIN_NONE);
                    if (bus.chg_ack && r_chg_req) begin
                        w_credit_nxt = r_credit - CREDIT_W'(1);
                        if (r_credit == CREDIT_W'(1)) w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_price    <= '0;
            r_disp_id  <= '0;
            r_coin_rej <= 1'b0;
            r_sel_nack <= 1'b0;
            r_fault    <= 1'b0;
            r_disp_req <= 1'b0;
            r_chg_req  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_price    <= w_price_nxt;
            r_disp_id  <= w_disp_id_nxt;
            r_coin_rej <= w_coin_rej_nxt;
            r_sel_nack <= w_sel_nack_nxt;
            r_fault    <= w_fault_nxt;
            r_disp_req <= (w_state_nxt == ST_DISPENSE);
            r_chg_req  <= (w_state_nxt == ST_CHANGE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.disp_req = r_disp_req;
    assign bus.disp_id  = r_disp_id;
    assign bus.chg_req  = r_chg_req;
    assign bus.credit   = r_credit;
    assign bus.busy     = r_busy;
    assign bus.coin_rej = r_coin_rej;
    assign bus.sel_nack = r_sel_nack;
    assign bus.fault    = r_fault;
endmodule

// File: tb/tb_vend_sequencer.sv
// Purpose: self-checking bench for vend_sequencer with a transaction-level reference model.
// Latency: model outputs become visible one clock after the inputs it consumed.
// Backpressure: motor and change unit are driven directly by the directed vectors.
module tb_vend_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vend_if u_if();

    vend_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: credit in units, mode 0 = waiting, 1 = motor running, 2 = paying out.
    int price_tab [4] = '{3, 4, 5, 6};
    int m_credit, m_mode, m_id, m_age, m_paid, m_rej, m_nack, m_fault;
    bit m_live;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_credit = 0; m_mode = 0; m_id = 0; m_age = 0; m_paid = 0;
        m_rej = 0; m_nack = 0; m_fault = 0; m_live = 1'b0;
    endtask

    task automatic m_step();
        int coinv, left;
        m_rej = 0; m_nack = 0; m_fault = 0;
        if (!m_live) begin
            m_live = 1'b1;
            return;
        end
        coinv = (u_if.coin == 2'd1) ? 1 : (u_if.coin == 2'd2) ? 2 : 0;
        if (m_mode == 0) begin
            left = m_credit;
            if (u_if.cancel) begin
                if (m_credit > 0) m_mode = 2;
            end else if (u_if.sel_valid) begin
                if (m_credit >= price_tab[u_if.sel_id]) begin
                    left   = m_credit - price_tab[u_if.sel_id];
                    m_paid = price_tab[u_if.sel_id];
                    m_id   = int'(u_if.sel_id);
                    m_age  = 0;
                    m_mode = 1;
                end else begin
                    m_nack = 1;
                end
            end
            if (u_if.coin == 2'd3)          m_rej = 1;
            else if (coinv > 0) begin
                if (left + coinv <= 12)     left += coinv;
                else                        m_rej = 1;
            end
            m_credit = left;
        end else if (m_mode == 1) begin
            if (u_if.coin != 2'd0) m_rej = 1;
            m_age++;
            if (u_if.disp_done) begin
                m_mode = (m_credit > 0) ? 2 : 0;
            end else if (m_age == 64) begin
                m_credit += m_paid;
                m_fault = 1;
                m_mode  = 0;
            end
        end else begin
            if (u_if.coin != 2'd0) m_rej = 1;
            if (u_if.chg_ack) m_credit--;
            if (m_credit == 0) m_mode = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("credit",   int'(u_if.credit),   m_credit);
            chk("disp_req", int'(u_if.disp_req), int'(m_mode == 1));
            chk("chg_req",  int'(u_if.chg_req),  int'(m_mode == 2));
            chk("busy",     int'(u_if.busy),     int'(m_mode != 0));
            chk("disp_id",  int'(u_if.disp_id),  m_id);
            chk("coin_rej", int'(u_if.coin_rej), m_rej);
            chk("sel_nack", int'(u_if.sel_nack), m_nack);
            chk("fault",    int'(u_if.fault),    m_fault);
        end
    end

    task automatic cyc(input int coin, input int selv, input int sid,
                       input int canc, input int done, input int ack);
        @(negedge clk);
        u_if.coin      = 2'(coin);
        u_if.sel_valid = 1'(selv);
        u_if.sel_id    = 2'(sid);
        u_if.cancel    = 1'(canc);
        u_if.disp_done = 1'(done);
        u_if.chg_ack   = 1'(ack);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        u_if.coin = 2'd0; u_if.sel_valid = 1'b0; u_if.sel_id = 2'd0;
        u_if.cancel = 1'b0; u_if.disp_done = 1'b0; u_if.chg_ack = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credit",   int'(u_if.credit),   0);
        chk("rst_busy",     int'(u_if.busy),     0);
        chk("rst_disp_req", int'(u_if.disp_req), 0);
        chk("rst_chg_req",  int'(u_if.chg_req),  0);
        chk("rst_coin_rej", int'(u_if.coin_rej), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        do_reset();
        // First edge after release must not react, even to a bad coin and a selection.
        cyc(3, 1, 0, 0, 0, 0);
        chk("first_edge_rej",  int'(u_if.coin_rej), 0);
        chk("first_edge_busy", int'(u_if.busy),     0);

        // 1 + 2 units, buy product 0, no change due.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0, 0);
        chk("exact_credit", int'(u_if.credit), 3);
        cyc(0, 1, 0, 0, 0, 0);
        chk("exact_after_sel", int'(u_if.credit), 0);
        chk("exact_disp_req",  int'(u_if.disp_req), 1);
        chk("exact_disp_id",   int'(u_if.disp_id), 0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0);
        chk("exact_idle", int'(u_if.busy), 0);

        // 4 units, buy product 0, one unit of change.
        cyc(2, 0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("chg1_credit", int'(u_if.credit), 1);
        idle(1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("chg1_req", int'(u_if.chg_req), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("chg1_done_credit", int'(u_if.credit), 0);
        chk("chg1_done_busy",   int'(u_if.busy), 0);

        // Too little credit for product 3, then cancel.
        cyc(2, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0);
        chk("nack_pulse",  int'(u_if.sel_nack), 1);
        chk("nack_credit", int'(u_if.credit), 2);
        idle(1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("cancel_chg_req", int'(u_if.chg_req), 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("cancel_drained", int'(u_if.credit), 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("cancel_zero_ignored", int'(u_if.busy), 0);

        // Fill to the ceiling, overflow and invalid coins are rejected.
        for (int i = 0; i < 6; i++) cyc(2, 0, 0, 0, 0, 0);
        chk("full_credit", int'(u_if.credit), 12);
        cyc(1, 0, 0, 0, 0, 0);
        chk("overflow_rej",    int'(u_if.coin_rej), 1);
        chk("overflow_credit", int'(u_if.credit), 12);
        cyc(3, 0, 0, 0, 0, 0);
        chk("bad_coin_rej", int'(u_if.coin_rej), 1);

        // Purchase with a same-cycle coin: 12 - 3 + 2 = 11.
        cyc(2, 1, 0, 0, 0, 0);
        chk("sel_coin_credit", int'(u_if.credit), 11);
        cyc(1, 0, 0, 0, 0, 0);
        chk("disp_coin_rej", int'(u_if.coin_rej), 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(2, 1, 1, 1, 0, 0);
        chk("chg_coin_rej", int'(u_if.coin_rej), 1);
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("drain11_credit", int'(u_if.credit), 0);
        chk("drain11_busy",   int'(u_if.busy), 0);

        // Cancel wins over a simultaneous selection; acks with a gap.
        cyc(2, 0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("cancel_wins_disp", int'(u_if.disp_req), 0);
        chk("cancel_wins_credit", int'(u_if.credit), 4);
        cyc(0, 0, 0, 0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Motor never answers: refund after 64 waiting cycles.
        cyc(2, 0, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("to_disp_id", int'(u_if.disp_id), 1);
        idle(63);
        chk("to_still_req", int'(u_if.disp_req), 1);
        chk("to_no_fault",  int'(u_if.fault), 0);
        idle(1);
        chk("to_fault",    int'(u_if.fault), 1);
        chk("to_credit",   int'(u_if.credit), 4);
        chk("to_disp_low", int'(u_if.disp_req), 0);
        idle(1);
        chk("to_fault_pulse", int'(u_if.fault), 0);
        cyc(0, 0, 0, 0, 1, 1);

        // Reset in the middle of paying out 3 units.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("mid_chg_credit", int'(u_if.credit), 3);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_credit",  int'(u_if.credit), 0);
        chk("async_rst_chg_req", int'(u_if.chg_req), 0);
        chk("async_rst_busy",    int'(u_if.busy), 0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("post_rst_credit", int'(u_if.credit), 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE0, default 3, meaning price of product 0 in credit units.
REQ-002 SHALL have parameter PRICE1, default 4, meaning price of product 1.
REQ-003 SHALL have parameter PRICE2, default 5, meaning price of product 2.
REQ-004 SHALL have parameter PRICE3, default 6, meaning price of product 3.
REQ-005 SHALL have parameter CREDIT_MAX, default 12, meaning maximum credit held.
REQ-006 SHALL have parameter DISP_TIMEOUT, default 64, meaning cycles allowed for disp_done.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port coin, input, 2: 00 none, 01 = 1 unit, 10 = 2 units, 11 invalid.
REQ-010 SHALL have port sel_valid, input, 1, product selection strobe.
REQ-011 SHALL have port sel_id, input, 2, selected product, sampled with sel_valid.
REQ-012 SHALL have port cancel, input, 1, refund request.
REQ-013 SHALL have port disp_req, output, 1, dispense request to the motor unit.
REQ-014 SHALL have port disp_id, output, 2, product being dispensed.
REQ-015 SHALL have port disp_done, input, 1, dispense complete from the motor unit.
REQ-016 SHALL have port chg_req, output, 1, request to return one change unit.
REQ-017 SHALL have port chg_ack, input, 1, one change unit returned.
REQ-018 SHALL have port credit, output, 4, current credit.
REQ-019 SHALL have ports busy, coin_rej, sel_nack, fault: outputs, 1 bit each; the last three are one-cycle pulses.

Function
REQ-020 SHALL implement states IDLE, DISPENSE, CHANGE; busy = (state != IDLE); all outputs registered.
REQ-021 IDLE: a valid coin SHALL add its value if credit+value <= CREDIT_MAX; otherwise credit SHALL be unchanged and coin_rej SHALL pulse the next cycle.
REQ-022 Coin 11, or any coin in DISPENSE/CHANGE, SHALL be discarded with a coin_rej pulse.
REQ-023 IDLE, sel_valid with credit >= price(sel_id): credit -= price, disp_id <= sel_id, go to DISPENSE; disp_req SHALL be high from the next cycle.
REQ-024 IDLE, sel_valid with credit < price: sel_nack SHALL pulse; state and credit SHALL be unchanged.
REQ-025 The price check SHALL use pre-coin credit; a coin in the same cycle SHALL still be added after the deduction, subject to REQ-021.
REQ-026 IDLE, cancel with credit > 0: go to CHANGE; cancel with credit = 0 SHALL be ignored; cancel SHALL win over a simultaneous sel_valid.
REQ-027 DISPENSE: disp_req SHALL stay high until disp_done is sampled high, then go to CHANGE if credit > 0, else IDLE.
REQ-028 DISPENSE timeout: if disp_done is absent for DISP_TIMEOUT cycles, disp_req SHALL drop, the price SHALL be restored to credit, fault SHALL pulse, and the state SHALL go to IDLE.
REQ-029 CHANGE: chg_req SHALL be high; each cycle with chg_req and chg_ack high SHALL decrement credit by 1; back-to-back acks are legal; at credit 0, go to IDLE and deassert chg_req.
REQ-030 cancel, sel_valid, disp_done and chg_ack SHALL be ignored in states where they are not listed.

Reset
REQ-031 On rst_n low: state IDLE; credit 0; disp_id 0; timeout counter 0; all outputs 0; in-flight dispense or change abandoned.
REQ-032 Reset release SHALL be registered on the first rising clk edge after rst_n goes high; no pulse output SHALL be asserted on that edge.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum, coin encodings, CREDIT_W = 4 and the default price table.
REQ-034 The DISPENSE timeout SHALL be a sub-module vend_timer (load/clear, expired flag), parameterised by DISP_TIMEOUT.

Verification
REQ-035 Coin 01, then coin 10, then sel 0 -> credit 3; disp_req with disp_id 0; disp_done -> IDLE with credit 0, chg_req never high.
REQ-036 Coin 10 twice, then sel 0 -> credit 1 after deduction; after disp_done, chg_req high, one chg_ack -> credit 0, IDLE.
REQ-037 Credit 2, sel 3 -> sel_nack pulse, credit stays 2; then cancel -> two chg_ack cycles -> credit 0.
REQ-038 Credit 12, then coin 01 -> coin_rej pulse, credit stays 12; coin 11 at any credit -> coin_rej.
REQ-039 Credit 4, sel 1, no disp_done for 64 cycles -> fault pulse, disp_req low, credit 4, IDLE.
REQ-040 rst_n low mid-CHANGE with credit 3 -> credit 0, chg_req 0, busy 0 immediately.
